shift_l_iter_nbit: RTL
======================

Name: shift_l_iter_nbit

Overview:
Multi-cycle, area-reduced n-bit logical left shifter for PIM compute paths. It keeps a single accumulator register and applies one binary shift stage per cycle: stage k shifts by 2^k when B[k]=1. Over SHIFT_WIDTH cycles it produces the same result as the combinational log-shifter. Operands arrive over a valid/ready handshake from the operand-fetch stage, and the result leaves over a valid/ready handshake to the writeback stage.

Parameters:
WIDTH, 32, data width of operand and result
SHIFT_WIDTH, 5, width of shift amount; number of iteration cycles

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  synchronous reset, active-high
in_valid  input  1  operand pair valid
in_ready  output  1  block can accept operands
in_a  input  WIDTH  value to shift
in_b  input  SHIFT_WIDTH  unsigned shift amount
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out_y  output  WIDTH  shifted result
busy  output  1  high while in SHIFT or DONE

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst.
- When rst is sampled high: state=IDLE; acc=0; amt=0; k=0; out_valid=0; out_y=0. While rst is high, in_valid is ignored.
- in_ready = (state==IDLE). busy = (state!=IDLE). out_valid = (state==DONE). out_y is driven from acc.
- IDLE:
  - on an edge with in_valid && in_ready: acc<=in_a, amt<=in_b, k<=0, go to SHIFT.
  - otherwise hold.
- SHIFT, one stage per cycle:
  - acc <= amt[k] ? (acc << (1<<k)) : acc.
  - Shifts are logical; zeros fill the LSBs; bits beyond WIDTH-1 are discarded.
  - A stage distance >= WIDTH yields 0 when its bit is set.
  - k <= k+1. When k==SHIFT_WIDTH-1, go to DONE instead.
  - k is a ceil(log2(SHIFT_WIDTH+1))-bit counter.
- DONE:
  - out_valid=1. out_y and acc are held stable until out_ready.
  - on an edge with out_valid && out_ready: go to IDLE.
- Latency is fixed and independent of in_b:
  - operand accept edge at T; out_valid high from edge T+SHIFT_WIDTH.
  - in_b=0 still takes SHIFT_WIDTH cycles (no early exit).
- Throughput: no overlap. in_ready=0 during SHIFT and DONE. The earliest next accept is the edge after the output handshake, so the minimum period is SHIFT_WIDTH+2 cycles.
- out_y after the output handshake: retains the last result while in IDLE. It becomes meaningful again only when out_valid=1.
- Reset mid-operation (SHIFT or DONE): the transaction is dropped, out_valid never asserts for it, and in_ready=1 on the first cycle after rst deasserts.
- Simultaneous rst and handshake: rst wins; nothing is captured or emitted.
- in_a and in_b are sampled only at accept; changes afterwards have no effect.
- Functional equivalence: out_y == (in_a << in_b) truncated to WIDTH bits, for all in_a and in_b.

Test Plan:
1. Defaults, in_a=0x00000001, in_b=5, out_ready=1 → out_valid rises exactly 5 cycles after accept with out_y=0x00000020; in_ready=1 the cycle after the handshake.
2. in_a=0xFFFFFFFF, in_b=31 → out_y=0x80000000. Then in_a=0xA5A5A5A5, in_b=0 → out_y=0xA5A5A5A5 with the same 5-cycle latency.
3. Backpressure: in_a=0x12345678, in_b=4, out_ready=0 for 3 cycles after out_valid → out_y=0x23456780 stable, out_valid=1, in_ready=0 throughout; the handshake on cycle 4 returns to IDLE.
4. rst pulsed for 1 cycle, 2 cycles after accepting in_a=0x1, in_b=3 → out_valid never rises; in_ready=1, busy=0, out_y=0 after reset.
5. WIDTH=8, SHIFT_WIDTH=4: in_a=0xFF, in_b=9 → out_y=0x00; in_a=0x81, in_b=1 → out_y=0x02; latency 4 cycles each.
6. Randomized back-to-back, 1000 transactions with random out_ready stalls → every out_y equals (in_a<<in_b) masked to WIDTH, in order, with no dropped or duplicate results.

Source files
------------

// File: rtl/shift_l_iter_nbit.sv
// Iterative logical left shifter: one binary log-shifter stage per cycle on a
// single accumulator, with valid/ready handshakes on the operand and result sides.
module shift_l_iter_nbit #(
    parameter int WIDTH       = 32,
    parameter int SHIFT_WIDTH = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_a,
    input  logic [SHIFT_WIDTH-1:0] in_b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_y,
    output logic                   busy
);

    localparam int KW = $clog2(SHIFT_WIDTH + 1);
    // Stages at or beyond this index move every bit past the MSB.
    localparam int ZERO_STAGE = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t                 stateQ;
    logic [WIDTH-1:0]       accQ;
    logic [WIDTH-1:0]       accD;
    logic [SHIFT_WIDTH-1:0] amtQ;
    logic [KW-1:0]          kQ;
    logic                   inReadyQ;
    logic                   outValidQ;
    logic                   busyQ;
    logic                   lastStage;

    assign lastStage = (kQ == KW'(SHIFT_WIDTH - 1));

    always_comb begin
        accD = accQ;
        for (int s = 0; s < SHIFT_WIDTH; s++) begin
            if ((kQ == KW'(s)) && amtQ[s]) begin
                if (s >= ZERO_STAGE) begin
                    accD = '0;
                end else begin
                    accD = accQ << (1 << s);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stateQ    <= IDLE;
            accQ      <= '0;
            amtQ      <= '0;
            kQ        <= '0;
            inReadyQ  <= 1'b1;
            outValidQ <= 1'b0;
            busyQ     <= 1'b0;
        end else begin
            case (stateQ)
                IDLE: begin
                    if (in_valid && inReadyQ) begin
                        stateQ   <= SHIFT;
                        accQ     <= in_a;
                        amtQ     <= in_b;
                        kQ       <= '0;
                        inReadyQ <= 1'b0;
                        busyQ    <= 1'b1;
                    end
                end
                SHIFT: begin
                    accQ <= accD;
                    if (lastStage) begin
                        stateQ    <= DONE;
                        outValidQ <= 1'b1;
                    end else begin
                        kQ <= kQ + KW'(1);
                    end
                end
                DONE: begin
                    if (outValidQ && out_ready) begin
                        stateQ    <= IDLE;
                        outValidQ <= 1'b0;
                        inReadyQ  <= 1'b1;
                        busyQ     <= 1'b0;
                    end
                end
                default: begin
                    stateQ    <= IDLE;
                    inReadyQ  <= 1'b1;
                    outValidQ <= 1'b0;
                    busyQ     <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = inReadyQ;
    assign out_valid = outValidQ;
    assign busy      = busyQ;
    assign out_y     = accQ;

endmodule
